// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluMul = 4'b1000;
  localparam logic [3:0] AluDiv = 4'b1001;
  localparam logic [3:0] AluXor = 4'b1010;
  localparam logic [3:0] AluNor = 4'b1100;
  localparam logic [3:0] AluNop = 4'b1111;

  localparam int unsigned StatZero = 7;
  localparam int unsigned StatNeg  = 4;
  localparam int unsigned StatDivz = 2;

endpackage

// File: rtl/alu_arb_pick.sv
// One-hot grant selection between two requesters.
// ALU_ARB_FIXED_PRIO_EN makes requester 0 win every tie and ignores ptr.
module alu_arb_pick (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ptr;
`endif

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        grant = 2'b01;
`else
        // ptr names the requester that currently holds priority
        grant = ptr ? 2'b10 : 2'b01;
`endif
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arb.sv
// Arbitrates two requesters onto one external ALU, one operation in flight.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module alu_arb
  import alu_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned STAT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  input  logic              rsp0_ready,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [STAT_W-1:0] rsp_status,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [STAT_W-1:0] alu_status
);

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic              owner_q;
  logic [DATA_W-1:0] result_q;
  logic [STAT_W-1:0] status_q;
  logic [1:0]        grant;
  logic              pick_ptr;
  logic              accept;
  logic              rsp_done;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign pick_ptr = 1'b0;
`else
  logic rr_ptr_q;
  assign pick_ptr = rr_ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
    end else if (accept) begin
      rr_ptr_q <= ~grant[1];
    end
  end
`endif

  alu_arb_pick u_pick (
    .valid (({req1_valid, req0_valid})),
    .ptr   (pick_ptr),
    .grant (grant)
  );

  assign accept   = (state_q == StIdle) && (grant != 2'b00);
  assign rsp_done = owner_q ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (rsp_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req0_ready = (state_q == StIdle) && grant[0];
    req1_ready = (state_q == StIdle) && grant[1];
    rsp0_valid = (state_q == StResp) && !owner_q;
    rsp1_valid = (state_q == StResp) && owner_q;
    // All-ones outside EXEC gives the ALU an edge even for repeated opcodes
    alu_ctrl   = '1;
    alu_op1    = '0;
    alu_op2    = '0;
    if (state_q == StExec) begin
      alu_ctrl = ctrl_q;
      alu_op1  = a_q;
      alu_op2  = b_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= '1;
      a_q      <= '0;
      b_q      <= '0;
      owner_q  <= 1'b0;
      result_q <= '0;
      status_q <= '0;
    end else begin
      if (accept) begin
        owner_q <= grant[1];
        ctrl_q  <= grant[1] ? req1_ctrl : req0_ctrl;
        a_q     <= grant[1] ? req1_a : req0_a;
        b_q     <= grant[1] ? req1_b : req0_b;
      end
      if (state_q == StExec) begin
        result_q <= alu_result;
        status_q <= alu_status;
      end
    end
  end

  assign rsp_result = result_q;
  assign rsp_status = status_q;

endmodule

// File: tb/tb_alu_arb.sv
// Directed self-checking bench for alu_arb with a behavioural ALU model.
module tb_alu_arb;
  import alu_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic [31:0] req0_a, req1_a, req0_b, req1_b;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] rsp_result;
  logic [7:0]  rsp_status;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_op1, alu_op2, alu_result;
  logic [7:0]  alu_status;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_g [4];

  always #5 clk = ~clk;

  alu_arb dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .req0_ctrl  (req0_ctrl),
    .req1_ctrl  (req1_ctrl),
    .req0_a     (req0_a),
    .req1_a     (req1_a),
    .req0_b     (req0_b),
    .req1_b     (req1_b),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_ready (rsp1_ready),
    .rsp_result (rsp_result),
    .rsp_status (rsp_status),
    .alu_ctrl   (alu_ctrl),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_result (alu_result),
    .alu_status (alu_status)
  );

  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      AluAdd:  alu_result = alu_op1 + alu_op2;
      AluSub:  alu_result = alu_op1 - alu_op2;
      AluAnd:  alu_result = alu_op1 & alu_op2;
      AluOr:   alu_result = alu_op1 | alu_op2;
      AluXor:  alu_result = alu_op1 ^ alu_op2;
      AluNor:  alu_result = ~(alu_op1 | alu_op2);
      AluSlt:  alu_result = {31'd0, $signed(alu_op1) < $signed(alu_op2)};
      AluMul:  alu_result = alu_op1 * alu_op2;
      AluDiv:  alu_result = (alu_op2 == 0) ? 32'hFFFF_FFFF : alu_op1 / alu_op2;
      default: alu_result = '0;
    endcase
    alu_status           = '0;
    alu_status[StatZero] = (alu_result == 0);
    alu_status[StatNeg]  = alu_result[31];
    alu_status[StatDivz] = (alu_ctrl == AluDiv) && (alu_op2 == 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_ctrl = AluNop; req1_ctrl = AluNop;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;

    // Reset state
    reset_dut();
    #1;
    chk("rst_req_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_status", {24'd0, rsp_status}, 32'd0);
    chk("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'hF);
    chk("rst_op1", alu_op1, 32'd0);
    chk("rst_op2", alu_op2, 32'd0);

    // Single ADD 5+7 on requester 0
    req0_valid = 1; req0_ctrl = AluAdd; req0_a = 5; req0_b = 7;
    #1;
    chk("add_ready0", {31'd0, req0_ready}, 32'd1);
    chk("add_ready1", {31'd0, req1_ready}, 32'd0);
    chk("add_ctrl_pre", {28'd0, alu_ctrl}, 32'hF);
    @(negedge clk); req0_valid = 0; #1;
    chk("add_exec_ctrl", {28'd0, alu_ctrl}, 32'h2);
    chk("add_exec_op1", alu_op1, 32'd5);
    chk("add_exec_op2", alu_op2, 32'd7);
    chk("add_exec_rsp", {31'd0, rsp0_valid}, 32'd0);
    @(negedge clk); #1;
    chk("add_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
    chk("add_result", rsp_result, 32'd12);
    chk("add_ctrl_post", {28'd0, alu_ctrl}, 32'hF);
    chk("add_op1_post", alu_op1, 32'd0);
    rsp0_ready = 1;
    @(negedge clk); rsp0_ready = 0; #1;
    chk("add_rsp_done", {31'd0, rsp0_valid}, 32'd0);

    // Both requesters continuously valid
    reset_dut();
    req0_valid = 1; req0_ctrl = AluAdd; req0_a = 1; req0_b = 2;
    req1_valid = 1; req1_ctrl = AluOr;  req1_a = 4; req1_b = 1;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_grant%0d", i), {30'd0, req1_ready, req0_ready}, {30'd0, exp_g[i]});
      @(negedge clk);
      @(negedge clk); #1;
      chk($sformatf("rr_rsp%0d", i), {30'd0, rsp1_valid, rsp0_valid}, {30'd0, exp_g[i]});
      chk($sformatf("rr_res%0d", i), rsp_result, exp_g[i][1] ? 32'd5 : 32'd3);
      @(negedge clk);
    end
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;

    // SUB 3-3 on requester 1, response back-pressured; stray rsp0_ready
    req1_valid = 1; req1_ctrl = AluSub; req1_a = 3; req1_b = 3; rsp0_ready = 1;
    #1;
    chk("sub_ready1", {31'd0, req1_ready}, 32'd1);
    @(negedge clk); req1_valid = 0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("sub_hold_valid%0d", k), {30'd0, rsp1_valid, rsp0_valid}, 32'd2);
      chk($sformatf("sub_hold_res%0d", k), rsp_result, 32'd0);
      chk($sformatf("sub_hold_stat%0d", k), {24'd0, rsp_status}, 32'h80);
      @(negedge clk);
    end
    rsp1_ready = 1;
    @(negedge clk); #1;
    chk("sub_done", {31'd0, rsp1_valid}, 32'd0);
    rsp1_ready = 0; rsp0_ready = 0;

    // Back-to-back identical AND opcodes on requester 0
    req0_valid = 1; req0_ctrl = AluAnd; req0_a = 32'hF0; req0_b = 32'h3C;
    #1;
    chk("and1_ready", {31'd0, req0_ready}, 32'd1);
    @(negedge clk); req0_a = 32'h0F; req0_b = 32'hFF; #1;
    chk("and1_exec_ctrl", {28'd0, alu_ctrl}, 32'h0);
    chk("and1_exec_op1", alu_op1, 32'hF0);
    @(negedge clk); #1;
    chk("and1_result", rsp_result, 32'h30);
    chk("and1_rsp", {31'd0, rsp0_valid}, 32'd1);
    chk("and_gap_ctrl", {28'd0, alu_ctrl}, 32'hF);
    rsp0_ready = 1;
    @(negedge clk); #1;
    chk("and2_ready", {31'd0, req0_ready}, 32'd1);
    chk("and2_pre_ctrl", {28'd0, alu_ctrl}, 32'hF);
    @(negedge clk); req0_valid = 0; #1;
    chk("and2_exec_ctrl", {28'd0, alu_ctrl}, 32'h0);
    chk("and2_exec_op1", alu_op1, 32'h0F);
    chk("and2_result_kept", rsp_result, 32'h30);
    @(negedge clk); #1;
    chk("and2_result", rsp_result, 32'h0F);
    chk("and2_status", {24'd0, rsp_status}, 32'h00);
    @(negedge clk); #1;
    chk("and2_done", {31'd0, rsp0_valid}, 32'd0);
    rsp0_ready = 0;

    // Reset during EXEC drops the operation
    req0_valid = 1; req0_ctrl = AluAdd; req0_a = 1; req0_b = 1;
    @(negedge clk); req0_valid = 0; rst = 1; #1;
    chk("rexec_ctrl_in_exec", {28'd0, alu_ctrl}, 32'h2);
    @(negedge clk); #1;
    chk("rexec_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("rexec_result", rsp_result, 32'd0);
    chk("rexec_ctrl", {28'd0, alu_ctrl}, 32'hF);
    chk("rexec_op1", alu_op1, 32'd0);
    rst = 0;
    @(negedge clk); #1;
    chk("rexec_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);

    // DIV by zero
    req0_valid = 1; req0_ctrl = AluDiv; req0_a = 10; req0_b = 0;
    @(negedge clk); req0_valid = 0;
    @(negedge clk); #1;
    chk("div_rsp", {31'd0, rsp0_valid}, 32'd1);
    chk("div_result", rsp_result, 32'hFFFF_FFFF);
    chk("div_status", {24'd0, rsp_status}, 32'h14);
    rsp0_ready = 1;
    @(negedge clk); rsp0_ready = 0;
    req0_valid = 1; req0_ctrl = AluAdd; req0_a = 2; req0_b = 2; #1;
    chk("div_back_idle_rsp", {31'd0, rsp0_valid}, 32'd0);
    chk("div_back_idle_ready", {31'd0, req0_ready}, 32'd1);
    @(negedge clk); req0_valid = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter CTRL_W, default 4, ALU control width.
REQ-003 SHALL have parameter STAT_W, default 8, ALU status width.
REQ-004 Ports, in this order:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid/req1_valid  in  1  requester N has an operation.
- req0_ready/req1_ready  out  1  operation accepted this cycle.
- req0_ctrl/req1_ctrl  in  CTRL_W  ALU opcode.
- req0_a/req1_a, req0_b/req1_b  in  DATA_W  operands.
- rsp0_valid/rsp1_valid  out  1  response for requester N.
- rsp0_ready/rsp1_ready  in  1  requester N consumes the response.
- rsp_result  out  DATA_W  registered ALU result.
- rsp_status  out  STAT_W  registered ALU status.
- alu_ctrl  out  CTRL_W  to ALU.
- alu_op1/alu_op2  out  DATA_W  to ALU.
- alu_result  in  DATA_W  from ALU.
- alu_status  in  STAT_W  from ALU.

Function
REQ-005 SHALL implement FSM states IDLE, EXEC, RESP; one operation in flight at a time.
REQ-006 In IDLE: SHALL assert reqN_ready only for the granted requester, only when reqN_valid=1, and for at most one requester per cycle.
REQ-007 On accept (valid&ready): SHALL register ctrl/a/b and the owner ID, then go to EXEC.
REQ-008 In EXEC (exactly 1 cycle): SHALL drive alu_ctrl/alu_op1/alu_op2 from the registers, capture alu_result/alu_status at the end of the cycle, then go to RESP.
REQ-009 Outside EXEC: SHALL hold alu_ctrl=4'b1111 so every operation presents a control transition to the ALU, including back-to-back identical opcodes.
REQ-010 Outside EXEC: SHALL hold alu_op1=alu_op2=0.
REQ-011 In RESP: SHALL assert only the owner's rspN_valid, with rsp_result/rsp_status stable.
REQ-012 In RESP: SHALL hold until rspN_ready=1, then go to IDLE on the same edge.
REQ-013 Latency SHALL be: accept at edge T, rspN_valid high in cycle T+2 (first possible), next accept no earlier than the cycle after the response handshake.
REQ-014 Arbitration SHALL be round-robin: with both valid, grant the requester not served last.
REQ-015 Round-robin: after reset, requester 0 has priority.
REQ-016 Round-robin: the last-served pointer SHALL update only on accept.
REQ-017 A single valid requester SHALL be granted regardless of the pointer.
REQ-018 reqN_valid dropping in IDLE before accept SHALL cause no state change.
REQ-019 rsp_result/rsp_status SHALL retain their last captured values in IDLE and EXEC.
REQ-020 rspN_ready asserted while rspN_valid=0 SHALL be ignored.

Reset
REQ-021 On rst=1 at a clock edge: SHALL enter IDLE from any state, dropping any in-flight operation with no response.
REQ-022 Reset values SHALL be: all reqN_ready=0, rspN_valid=0, rsp_result=0, rsp_status=0, alu_ctrl=4'b1111, alu_op1=alu_op2=0, RR pointer at requester 0.
REQ-023 rst SHALL take precedence over any simultaneous handshake.

Configuration
REQ-024 Macro ALU_ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL always win ties and the RR pointer logic SHALL be removed.
REQ-025 When ALU_ARB_FIXED_PRIO_EN is undefined, round-robin per REQ-014..REQ-016 SHALL apply.

Structure
REQ-026 A shared package SHALL hold the FSM state enum (IDLE/EXEC/RESP), ALU opcode constants (ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111, NOR 1100, MUL 1000, DIV 1001, XOR 1010, NOP 1111), and the status bit indices (ZERO=7, NEG=4, DIVZ=2).
REQ-027 The grant logic SHALL be sub-module alu_arb_pick: inputs valids and the last-served pointer; output a one-hot grant.

Verification
REQ-028 Scenario: req0 ADD a=5, b=7 alone -> req0_ready at T, rsp0_valid at T+2, rsp_result=12; alu_ctrl 1111 before and after EXEC.
REQ-029 Scenario: both valid continuously, 4 ops -> grants 0,1,0,1; with ALU_ARB_FIXED_PRIO_EN -> 0,0,0,0.
REQ-030 Scenario: req1 SUB a=3, b=3 -> rsp_result=0, rsp_status[7]=1; rsp1_valid held for 3 cycles while rsp1_ready=0, stable throughout.
REQ-031 Scenario: two back-to-back req0 AND ops (0xF0&0x3C, then 0x0F&0xFF) -> results 0x30 then 0x0F; the second shows a fresh ALU evaluation via the intervening 1111.
REQ-032 Scenario: rst asserted during EXEC -> next cycle IDLE, no rspN_valid, all outputs at reset values.
REQ-033 Scenario: req0 DIV a=10, b=0 -> response delivered with rsp_status[2] as produced by the ALU; arbiter returns to IDLE.
